// File: rtl/viterbi_sequencer.sv
// Main control FSM for the Viterbi POS-tagging datapath: INIT, recursion and backtrack phases.
// Optional abort input is compiled in when VITERBI_ABORT_EN is defined.
module viterbi_sequencer #(
  parameter int N_TAGS    = 4,
  parameter int MAX_WORDS = 16,
  localparam int TW = $clog2(N_TAGS),
  localparam int WW = $clog2(MAX_WORDS),
  localparam int LW = WW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [LW-1:0] n_words_i,
  input  logic          cmp_gt_i,
`ifdef VITERBI_ABORT_EN
  input  logic          abort_i,
`endif
  output logic [3:0]    q_o,
  output logic [WW-1:0] word_idx_o,
  output logic [TW-1:0] tag_idx_o,
  output logic [TW-1:0] prev_idx_o,
  output logic [TW-1:0] best_prev_o,
  output logic [WW-1:0] back_idx_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_EMIT      = 4'd1,
    S_STORE     = 4'd2,
    S_NEXT_WORD = 4'd3,
    S_TRANS     = 4'd4,
    S_CMP       = 4'd5,
    S_MAXW      = 4'd6,
    S_BACKTRACK = 4'd7,
    S_INIT      = 4'd8,
    S_DONE      = 4'd10
  } state_t;

  localparam logic [TW-1:0] TAG_LAST = TW'(N_TAGS - 1);

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [WW-1:0] word_q, word_d, back_q, back_d;
  logic [TW-1:0] tag_q, tag_d, prev_q, prev_d, best_q, best_d;
  logic          busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    tag_d   = tag_q;
    prev_d  = prev_q;
    best_d  = best_q;
    back_d  = back_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && (n_words_i != '0) && (n_words_i <= LW'(MAX_WORDS))) begin
          len_d   = n_words_i;
          word_d  = '0;
          tag_d   = '0;
          prev_d  = '0;
          best_d  = '0;
          back_d  = '0;
          state_d = S_INIT;
        end
      end
      S_INIT:  state_d = S_EMIT;
      S_EMIT:  state_d = S_STORE;
      S_STORE: begin
        if (tag_q != TAG_LAST) begin
          tag_d   = tag_q + 1'b1;
          state_d = (word_q == '0) ? S_EMIT : S_TRANS;
        end else begin
          state_d = S_NEXT_WORD;
        end
      end
      S_TRANS: state_d = S_CMP;
      S_CMP: begin
        // The first predecessor seeds the running argmax regardless of cmp_gt.
        if (cmp_gt_i || (prev_q == '0)) best_d = prev_q;
        if (prev_q != TAG_LAST) begin
          prev_d  = prev_q + 1'b1;
          state_d = S_TRANS;
        end else begin
          prev_d  = '0;
          state_d = S_MAXW;
        end
      end
      S_MAXW:  state_d = S_EMIT;
      S_NEXT_WORD: begin
        tag_d = '0;
        if (({1'b0, word_q} + LW'(1)) == len_q) begin
          back_d  = WW'(len_q - LW'(1));
          state_d = S_BACKTRACK;
        end else begin
          word_d  = word_q + 1'b1;
          state_d = S_TRANS;
        end
      end
      S_BACKTRACK: begin
        if (back_q == '0) state_d = S_DONE;
        else              back_d  = back_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef VITERBI_ABORT_EN
    if (abort_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d = S_IDLE;
      word_d  = '0;
      tag_d   = '0;
      prev_d  = '0;
      best_d  = '0;
      back_d  = '0;
    end
`endif
    // Status flags are registered from the next state so they align with q_o.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      tag_q   <= '0;
      prev_q  <= '0;
      best_q  <= '0;
      back_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      tag_q   <= tag_d;
      prev_q  <= prev_d;
      best_q  <= best_d;
      back_q  <= back_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q_o         = state_q;
  assign word_idx_o  = word_q;
  assign tag_idx_o   = tag_q;
  assign prev_idx_o  = prev_q;
  assign best_prev_o = best_q;
  assign back_idx_o  = back_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_viterbi_sequencer.sv
// Scoreboard bench for viterbi_sequencer: expected per-cycle state/index traces are queued
// when a sequence is started and compared cycle by cycle as the DUT steps through them.
module tb_viterbi_sequencer;
  localparam int NT = 4;
  localparam int MW = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] n_words_i = '0;
  logic       cmp_gt_i;
  logic       abort_i = 1'b0;
  logic [3:0] q_o, word_idx_o, back_idx_o;
  logic [1:0] tag_idx_o, prev_idx_o, best_prev_o;
  logic       busy_o, done_o;

  viterbi_sequencer #(.N_TAGS(NT), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_words_i(n_words_i), .cmp_gt_i(cmp_gt_i),
`ifdef VITERBI_ABORT_EN
    .abort_i(abort_i),
`endif
    .q_o(q_o), .word_idx_o(word_idx_o), .tag_idx_o(tag_idx_o), .prev_idx_o(prev_idx_o),
    .best_prev_o(best_prev_o), .back_idx_o(back_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Candidate wins only for tag 1 at predecessor 2.
  assign cmp_gt_i = (tag_idx_o == 2'd1) && (prev_idx_o == 2'd2);

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] w;
    logic [1:0] t;
    logic [1:0] p;
    logic [1:0] bp;
    logic [3:0] bk;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int done_seen;

  function automatic exp_t mk(int q, int w, int t, int p, int bp, int bk);
    exp_t e;
    e.q = 4'(q); e.w = 4'(w); e.t = 2'(t); e.p = 2'(p); e.bp = 2'(bp); e.bk = 4'(bk);
    e.busy = (q != 0);
    e.done = (q == 10);
    return e;
  endfunction

  function automatic exp_t cur();
    exp_t o;
    o.q = q_o; o.w = word_idx_o; o.t = tag_idx_o; o.p = prev_idx_o;
    o.bp = best_prev_o; o.bk = back_idx_o; o.busy = busy_o; o.done = done_o;
    return o;
  endfunction

  task automatic check(input string tag, input exp_t obs, input exp_t e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  // Expected trace from INIT through the IDLE following DONE.
  task automatic build(input int n);
    int bp = 0;
    sb.push_back(mk(8, 0, 0, 0, 0, 0));
    for (int w = 0; w < n; w++) begin
      for (int t = 0; t < NT; t++) begin
        if (w > 0) begin
          for (int p = 0; p < NT; p++) begin
            sb.push_back(mk(4, w, t, p, bp, 0));
            sb.push_back(mk(5, w, t, p, bp, 0));
            if (p == 0 || (t == 1 && p == 2)) bp = p;
          end
          sb.push_back(mk(6, w, t, 0, bp, 0));
        end
        sb.push_back(mk(1, w, t, 0, bp, 0));
        sb.push_back(mk(2, w, t, 0, bp, 0));
      end
      sb.push_back(mk(3, w, NT - 1, 0, bp, 0));
    end
    for (int b = n - 1; b >= 0; b--) sb.push_back(mk(7, n - 1, 0, 0, bp, b));
    sb.push_back(mk(10, n - 1, 0, 0, bp, 0));
    sb.push_back(mk(0, n - 1, 0, 0, bp, 0));
  endtask

  // Called at posedge+1; busy_at >= 0 pulses an extra start mid-run that must be ignored.
  task automatic run_seq(input int n, input int busy_at);
    int idx = 0;
    exp_t e;
    n_words_i = 5'(n);
    start_i = 1'b1;
    build(n);
    @(posedge clk); #1;
    start_i = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("seq%0d_c%0d", n, idx), cur(), e);
      if (idx == busy_at) begin
        start_i = 1'b1;
        n_words_i = 5'd1;
      end else begin
        start_i = 1'b0;
      end
      idx++;
      if (sb.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    start_i = 1'b0;
    $display("[TB] sequence n_words=%0d: %0d cycles compared", n, idx);
  endtask

  task automatic wait_state(input logic [3:0] code, input string tag);
    for (int i = 0; i < 300 && q_o != code; i++) begin
      @(posedge clk); #1;
    end
    check_bit(tag, q_o == code, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", cur(), mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", cur(), mk(0, 0, 0, 0, 0, 0));

    n_words_i = 5'd0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("ignore_len0", cur(), mk(0, 0, 0, 0, 0, 0));
    $display("[TB] start with n_words=0 applied");
    n_words_i = 5'd17; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("ignore_len17", cur(), mk(0, 0, 0, 0, 0, 0));
    $display("[TB] start with n_words=17 applied");

    run_seq(1, -1);
    @(posedge clk); #1;
    run_seq(2, 20);
    @(posedge clk); #1;

    n_words_i = 5'd2; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_state(4'd4, "reach_trans");
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_trans", cur(), mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", cur(), mk(0, 0, 0, 0, 0, 0));
    $display("[TB] asynchronous reset during TRANS applied");

    n_words_i = 5'd2; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_state(4'd5, "reach_cmp");
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
`ifdef VITERBI_ABORT_EN
    check("abort_to_idle", cur(), mk(0, 0, 0, 0, 0, 0));
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (done_o) done_seen++;
      @(posedge clk); #1;
    end
    check_bit("abort_no_done", done_seen == 0, 1'b1);
    $display("[TB] abort during CMP applied");
`else
    check_bit("no_abort_still_busy", busy_o, 1'b1);
    wait_state(4'd10, "no_abort_reach_done");
    check_bit("no_abort_done_pulse", done_o, 1'b1);
    @(posedge clk); #1;
    check_bit("no_abort_done_clears", done_o, 1'b0);
    $display("[TB] run without abort port completed");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/viterbi_sequencer.md
# viterbi_sequencer

Main control state machine of the Viterbi POS-tagging datapath. It steps through the initial, recursive and backtrack phases for a sentence of `n_words` words over `N_TAGS` tags, and publishes its 4-bit state code `Q`. The downstream output decoder turns `Q` into counter enables, mux selects and memory read/write strobes. It also exports the word, tag, predecessor and backtrack indices used to address the HMM, probability and POS-stack memories.

## Interface
- `N_TAGS`, 4: number of POS tags; power of two, at least 2.
- `MAX_WORDS`, 16: maximum sentence length; power of two.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin decoding; sampled only in IDLE.
- `n_words`, in, clog2(MAX_WORDS)+1: sentence length; latched on accepted start.
- `cmp_gt`, in, 1: comparator result, candidate > current max; sampled in CMP.
- `abort`, in, 1: present only when `VITERBI_ABORT_EN` is defined.
- `Q`, out, 4: state code.
- `word_idx`, out, clog2(MAX_WORDS): current word.
- `tag_idx`, out, clog2(N_TAGS): current tag (emission counter).
- `prev_idx`, out, clog2(N_TAGS): predecessor tag (transition counter).
- `best_prev`, out, clog2(N_TAGS): argmax predecessor of the current tag.
- `back_idx`, out, clog2(MAX_WORDS): backtrack word pointer.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: high only in DONE.

## Operation
State codes:
- IDLE=0
- EMIT=1
- STORE=2
- NEXT_WORD=3
- TRANS=4
- CMP=5
- MAXW=6
- BACKTRACK=7
- INIT=8
- DONE=10

Codes 9 and 11–15 are illegal and go to IDLE on the next edge.

Transitions:
- IDLE: on `start` with `n_words` in 1..MAX_WORDS, latch `n_words`, clear all indices, go to INIT. Any other `n_words` value ignores `start`.
- INIT → EMIT.
- EMIT → STORE.
- STORE:
  - If `tag_idx` < N_TAGS-1: increment `tag_idx`; go to EMIT when `word_idx`=0, otherwise to TRANS.
  - If `tag_idx` = N_TAGS-1: go to NEXT_WORD.
- TRANS → CMP.
- CMP:
  - Update `best_prev` to `prev_idx` if `cmp_gt`, or if `prev_idx`=0 (first candidate always loads).
  - If `prev_idx` < N_TAGS-1: increment `prev_idx`, go to TRANS.
  - Otherwise clear `prev_idx`, go to MAXW.
- MAXW → EMIT.
- NEXT_WORD: clear `tag_idx`.
  - If `word_idx`+1 = latched length: set `back_idx` = length-1, go to BACKTRACK.
  - Otherwise increment `word_idx`, go to TRANS.
- BACKTRACK: one cycle per word.
  - If `back_idx`=0, go to DONE.
  - Otherwise decrement `back_idx` and stay.
- DONE → IDLE, unconditionally.

Rules:
- `start` is ignored while `busy`.
- Indices never wrap. The terminal compares above bound every counter.

## Timing
- Reset values: `Q`=0 (IDLE); `word_idx`, `tag_idx`, `prev_idx`, `best_prev`, `back_idx` all 0; `busy`=0; `done`=0.
- Every output is registered. `Q` and the indices change only on clock edges, or asynchronously on reset.
- Per-word latency:
  - Word 0: 2·N_TAGS cycles.
  - Later words: N_TAGS·(2·N_TAGS+3) cycles.
  - Each word also spends 1 cycle in NEXT_WORD.
- Total start-to-DONE: 1 (INIT) + word cycles + n_words (BACKTRACK).
- `done` is a single-cycle pulse.
- Reset asserted mid-sequence forces IDLE and zero indices immediately; no partial state survives.

## Configuration
- `VITERBI_ABORT_EN` defined:
  - `abort` port exists.
  - `abort`=1 in any busy state other than DONE forces IDLE on the next edge and clears all indices; `done` is not pulsed.
  - `abort` has priority over all other transitions.
  - `abort` in IDLE has no effect.
- `VITERBI_ABORT_EN` undefined: no `abort` port; a sequence always runs to DONE.

## Test plan
- Reset with `rst_n`=0 mid-TRANS → `Q`=0, all indices 0, `busy`=0 without waiting for a clock edge.
- N_TAGS=4, `n_words`=1, `start` at edge k → INIT at k; EMIT/STORE alternate with `tag_idx` 0..3 through k+8; NEXT_WORD at k+9; BACKTRACK at k+10; DONE at k+11; IDLE at k+12.
- N_TAGS=4, `n_words`=2 → word 1 runs the TRANS/CMP loop 4× per tag; DONE at edge k+57; `back_idx` reads 1 then 0 in BACKTRACK.
- `cmp_gt` high only at `prev_idx`=2 for tag 1 → `best_prev`=2 in MAXW for tag 1; for the other tags `best_prev`=0.
- `start` with `n_words`=0, and `start` while busy → no state change.
- With `VITERBI_ABORT_EN`: `abort` in CMP → IDLE next edge, `done` never asserted. Without the macro, the same stimulus completes normally.
